// File: rtl/stopwatch_ctrl_if.sv
// Lap-memory write bus between the stopwatch controller and the lap RAM.
interface stopwatch_ctrl_if #(
   parameter int SIZE   = 4,
   parameter int ADDR_W = 8
);
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [4*SIZE-1:0] wdata;

   modport master (output we, addr, wdata);
   modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns button events into a gated 1 s tick, a
// one-cycle counter restart, and lap snapshots written to the lap memory.
//
//   state | meaning
//   IDLE  | time zeroed, waiting for start
//   RUN   | counting, ticks forwarded
//   PAUSE | counting halted, time held
//   STORE | one-cycle lap write, returns to ret
//   CLEAR | one-cycle restart pulse, then IDLE
module stopwatch_ctrl #(
   parameter int SIZE     = 4,
   parameter int ADDR_W   = 8,
   parameter int MAX_ADDR = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_stop,
   input  logic            lap,
   input  logic            clear,
   input  logic            pulse,
   input  logic [SIZE-1:0] seconds_units,
   input  logic [SIZE-1:0] seconds_tens,
   input  logic [SIZE-1:0] minutes_units,
   input  logic [SIZE-1:0] minutes_tens,
   output logic            pulse_fsm,
   output logic            restart,
   output logic            mem_full,
   output logic            running,
   stopwatch_ctrl_if.master mem
);

   localparam int PTR_W = (MAX_ADDR > 0) ? $clog2(MAX_ADDR + 1) : 1;

   typedef enum logic [2:0] {IDLE, RUN, PAUSE, STORE, CLEAR} state_t;

   state_t            state_q, state_d;
   state_t            ret_q, ret_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              full_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [4*SIZE-1:0] wdata_q, wdata_d;
   logic              restart_d;
   logic              running_d;

   assign mem.we    = we_q;
   assign mem.addr  = addr_q;
   assign mem.wdata = wdata_q;

   // A tick is forwarded whenever the registered run flag is up, which
   // includes a lap store taken from RUN, so no second is lost.
   assign pulse_fsm = pulse & running;

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ret_q    <= IDLE;
         ptr_q    <= '0;
         mem_full <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         restart  <= 1'b0;
         running  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         ptr_q    <= ptr_d;
         mem_full <= full_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         restart  <= restart_d;
         running  <= running_d;
      end
   end

   // Next-state and next-output decode; clear outranks start_stop outranks lap.
   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      ptr_d     = ptr_q;
      full_d    = mem_full;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      restart_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear)           state_d = CLEAR;
            else if (start_stop) state_d = RUN;
         end
         RUN: begin
            if (start_stop) state_d = PAUSE;
            else if (lap && !mem_full) begin
               state_d = STORE;
               ret_d   = RUN;
            end
         end
         PAUSE: begin
            if (clear)           state_d = CLEAR;
            else if (start_stop) state_d = RUN;
            else if (lap && !mem_full) begin
               state_d = STORE;
               ret_d   = PAUSE;
            end
         end
         STORE: begin
            state_d = ret_q;
            if (ptr_q == PTR_W'(MAX_ADDR)) full_d = 1'b1;
            else                           ptr_d  = ptr_q + 1'b1;
         end
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Entry actions: snapshot the digits as seen on the accepting cycle.
      if (state_d == STORE && state_q != STORE) begin
         we_d    = 1'b1;
         addr_d  = ADDR_W'(ptr_q);
         wdata_d = {minutes_tens, minutes_units, seconds_tens, seconds_units};
      end
      if (state_d == CLEAR && state_q != CLEAR) begin
         restart_d = 1'b1;
         ptr_d     = '0;
         full_d    = 1'b0;
      end

      running_d = (state_d == RUN) || (state_d == STORE && ret_d == RUN);
   end

endmodule
